// File: rtl/vid_pkg.sv
// Shared types and helpers for the video frame source.
// Control word layout and pattern codes live here.
package vid_pkg;

  localparam int CTRL_W = 36;

  localparam logic [1:0] PAT_RAMP  = 2'd0;
  localparam logic [1:0] PAT_HGRAD = 2'd1;
  localparam logic [1:0] PAT_VGRAD = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    CTRL,
    PIX,
    DONE
  } state_e;

  function automatic logic [CTRL_W-1:0] pack_ctrl(
    input logic [15:0] w,
    input logic [15:0] h
  );
    return {w, h, 4'h0};
  endfunction

endpackage

// File: rtl/vid_pattern_gen.sv
// Combinational pixel generator.
// Selects ramp, gradient or 8x8 checker from pixel coordinates.
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [1:0]    pattern_sel,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] seq,
  output logic [DW-1:0] pix
);

  always_comb begin
    pix = '0;
    unique case (pattern_sel)
      PAT_RAMP:  pix = seq;
      PAT_HGRAD: pix = x;
      PAT_VGRAD: pix = y;
      PAT_CHECK: pix = (x[3] ^ y[3]) ? '1 : '0;
      default:   pix = '0;
    endcase
  end

endmodule

// File: rtl/vid_frame_gen.sv
// Video frame source: control word then W*H pixels per frame,
// on a valid/ready stream with ready-latency 1.
module vid_frame_gen
  import vid_pkg::*;
#(
  parameter int DW        = 8,
  parameter int WMAX_LOG2 = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [WMAX_LOG2-1:0] cfg_w,
  input  logic [WMAX_LOG2-1:0] cfg_h,
  input  logic [1:0]           pattern_sel,
  output logic [CTRL_W-1:0]    control_out_data,
  output logic                 control_out_valid,
  output logic [DW-1:0]        source_data,
  output logic                 source_valid,
  input  logic                 source_ready,
  output logic                 busy,
  output logic                 frame_done
);

  state_e state_q, state_d;

  logic [WMAX_LOG2-1:0] w_q, w_d;
  logic [WMAX_LOG2-1:0] h_q, h_d;
  logic [WMAX_LOG2-1:0] x_q, x_d;
  logic [WMAX_LOG2-1:0] y_q, y_d;
  logic [1:0]           pat_q, pat_d;
  logic [DW-1:0]        seq_q, seq_d;
  logic                 last_q, last_d;

  logic [CTRL_W-1:0] ctrl_data_q, ctrl_data_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic [DW-1:0]     src_data_q, src_data_d;
  logic              src_valid_q, src_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic          grant;
  logic          start;
  logic          x_last;
  logic          y_last;
  logic [DW-1:0] pix;

  vid_pattern_gen #(
    .DW(DW)
  ) u_pat (
    .pattern_sel(pat_q),
    .x          (x_q[DW-1:0]),
    .y          (y_q[DW-1:0]),
    .seq        (seq_q),
    .pix        (pix)
  );

  assign grant  = (state_q == PIX) & source_ready & ~last_q;
  assign x_last = (x_q == w_q - 1'b1);
  assign y_last = (y_q == h_q - 1'b1);
  assign start  = enable & ((state_q == IDLE) | (state_q == DONE));

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    x_d          = x_q;
    y_d          = y_q;
    pat_d        = pat_q;
    seq_d        = seq_q;
    last_d       = last_q;
    ctrl_data_d  = ctrl_data_q;
    ctrl_valid_d = 1'b0;
    src_data_d   = src_data_q;
    src_valid_d  = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: ;
      CTRL: begin
        if (w_q == '0 || h_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = PIX;
        end
      end
      PIX: begin
        if (grant) begin
          src_valid_d = 1'b1;
          src_data_d  = pix;
          seq_d       = seq_q + 1'b1;
          if (x_last) begin
            x_d = '0;
            if (y_last) begin
              last_d  = 1'b1;
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Entering CTRL registers the strobe so it is high during CTRL itself.
    if (start) begin
      state_d      = CTRL;
      w_d          = cfg_w;
      h_d          = cfg_h;
      pat_d        = pattern_sel;
      x_d          = '0;
      y_d          = '0;
      last_d       = 1'b0;
      ctrl_data_d  = pack_ctrl(cfg_w, cfg_h);
      ctrl_valid_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pat_q        <= '0;
      seq_q        <= '0;
      last_q       <= 1'b0;
      ctrl_data_q  <= '0;
      ctrl_valid_q <= 1'b0;
      src_data_q   <= '0;
      src_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pat_q        <= pat_d;
      seq_q        <= seq_d;
      last_q       <= last_d;
      ctrl_data_q  <= ctrl_data_d;
      ctrl_valid_q <= ctrl_valid_d;
      src_data_q   <= src_data_d;
      src_valid_q  <= src_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign control_out_data  = ctrl_data_q;
  assign control_out_valid = ctrl_valid_q;
  assign source_data       = src_data_q;
  assign source_valid      = src_valid_q;
  assign busy              = busy_q;
  assign frame_done        = done_q;

endmodule
